zero_pad_streamer: RTL and testbench



---
 rtl/cnn_stream_pkg.sv | 15 +
 rtl/zero_pad_streamer_if.sv | 23 ++
 rtl/pos_counter.sv | 51 +++++
 rtl/zero_pad_streamer.sv | 118 +++++++++++
 tb/tb_zero_pad_streamer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN stream front end: FSM encoding and counter sizing.
package cnn_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAD  = 2'd1,
        ST_DATA = 2'd2
    } zp_state_t;

    // Counter width for a dimension of n positions; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zero_pad_streamer_if.sv
// Stream bundle around the zero-pad streamer: ready/valid source side, valid-only padded side.
interface zero_pad_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eol;
    logic                  frame_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data, out_sof, out_eol, frame_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data, out_sof, out_eol, frame_done
    );
endinterface

// File: rtl/pos_counter.sv
// Raster col/row position counter with end-of-row/end-of-frame flags and next-position lookahead.
module pos_counter
    import cnn_stream_pkg::*;
#(
    parameter int COLS = 34,
    parameter int ROWS = 34
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        advance,
    output logic [cnt_width(COLS)-1:0]  col,
    output logic [cnt_width(ROWS)-1:0]  row,
    output logic [cnt_width(COLS)-1:0]  next_col,
    output logic [cnt_width(ROWS)-1:0]  next_row,
    output logic                        end_of_row,
    output logic                        end_of_frame
);
    localparam int CW = cnt_width(COLS);
    localparam int RW = cnt_width(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;

    assign col          = col_reg;
    assign row          = row_reg;
    assign end_of_row   = (col_reg == COL_LAST);
    assign end_of_frame = end_of_row && (row_reg == ROW_LAST);

    // Position after one advance; wraps to (0,0) past the last position.
    always_comb begin
        next_col = col_reg + 1'b1;
        next_row = row_reg;
        if (end_of_row) begin
            next_col = '0;
            next_row = end_of_frame ? '0 : row_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (advance) begin
            col_reg <= next_col;
            row_reg <= next_row;
        end
    end

endmodule

// File: rtl/zero_pad_streamer.sv
// Wraps an IN_WIDTH x IN_HEIGHT raster in a PAD-wide border, one registered sample per clock.
// Optional ZERO_PAD_VALUE_EN: border word comes from pad_value, latched once per frame.
module zero_pad_streamer
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IN_WIDTH   = 32,
    parameter int IN_HEIGHT  = 32,
    parameter int PAD        = 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef ZERO_PAD_VALUE_EN
    input  logic [DATA_WIDTH-1:0] pad_value,
`endif
    zero_pad_streamer_if.slave    bus
);
    localparam int OW = IN_WIDTH + 2 * PAD;
    localparam int OH = IN_HEIGHT + 2 * PAD;
    localparam int CW = cnt_width(OW);
    localparam int RW = cnt_width(OH);

    zp_state_t             state_reg, state_next;
    logic                  emit, use_pad, next_border;
    logic [CW-1:0]         col, next_col;
    logic [RW-1:0]         row, next_row;
    logic                  end_of_row, end_of_frame;
    logic [DATA_WIDTH-1:0] pad_word;
    logic                  out_valid_reg, out_sof_reg, out_eol_reg, frame_done_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;

    pos_counter #(
        .COLS (OW),
        .ROWS (OH)
    ) u_pos (
        .clk          (clk),
        .reset        (reset),
        .advance      (emit),
        .col          (col),
        .row          (row),
        .next_col     (next_col),
        .next_row     (next_row),
        .end_of_row   (end_of_row),
        .end_of_frame (end_of_frame)
    );

    assign next_border = (next_row < RW'(PAD)) || (next_row >= RW'(OH - PAD)) ||
                         (next_col < CW'(PAD)) || (next_col >= CW'(OW - PAD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Frames always open on a border sample, so IDLE hands straight to PAD.
    always_comb begin
        state_next = state_reg;
        emit       = 1'b0;
        use_pad    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) state_next = ST_PAD;
            end
            ST_PAD: begin
                emit    = 1'b1;
                use_pad = 1'b1;
                if (end_of_frame)      state_next = ST_IDLE;
                else if (!next_border) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bus.in_valid) begin
                    emit = 1'b1;
                    if (next_border) state_next = ST_PAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef ZERO_PAD_VALUE_EN
    logic [DATA_WIDTH-1:0] pad_value_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pad_value_reg <= '0;
        else if (state_reg == ST_IDLE && state_next == ST_PAD)
            pad_value_reg <= pad_value;
    end

    assign pad_word = pad_value_reg;
`else
    assign pad_word = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_sof_reg    <= 1'b0;
            out_eol_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            out_valid_reg  <= emit;
            out_data_reg   <= !emit ? '0 : (use_pad ? pad_word : bus.in_data);
            out_sof_reg    <= emit && (row == '0) && (col == '0);
            out_eol_reg    <= emit && end_of_row;
            frame_done_reg <= emit && end_of_frame;
        end
    end

    assign bus.in_ready   = (state_reg == ST_DATA);
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.out_sof    = out_sof_reg;
    assign bus.out_eol    = out_eol_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_zero_pad_streamer.sv
// Randomized bench for zero_pad_streamer against a raster-enumeration model of the padded frame.
// Two instances: 4x3 with PAD=1 and 2x2 with PAD=2; ZERO_PAD_VALUE_EN adds the pad_value frame.
module tb_zero_pad_streamer;
    localparam int DW = 32;
    localparam int AW = 4, AH = 3, AP = 1;
    localparam int BW = 2, BH = 2, BP = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          done;
        logic          border;
    } samp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    zero_pad_streamer_if #(.DATA_WIDTH(DW)) ifa ();
    zero_pad_streamer_if #(.DATA_WIDTH(DW)) ifb ();

`ifdef ZERO_PAD_VALUE_EN
    logic [DW-1:0] pad_value_a = '0;
    logic [DW-1:0] pad_value_b = '0;
    bit            pad_chg_mode = 1'b0;
`endif

    zero_pad_streamer #(.DATA_WIDTH(DW), .IN_WIDTH(AW), .IN_HEIGHT(AH), .PAD(AP)) dut_a (
        .clk       (clk),
        .reset     (reset),
`ifdef ZERO_PAD_VALUE_EN
        .pad_value (pad_value_a),
`endif
        .bus       (ifa)
    );

    zero_pad_streamer #(.DATA_WIDTH(DW), .IN_WIDTH(BW), .IN_HEIGHT(BH), .PAD(BP)) dut_b (
        .clk       (clk),
        .reset     (reset),
`ifdef ZERO_PAD_VALUE_EN
        .pad_value (pad_value_b),
`endif
        .bus       (ifb)
    );

    samp_t         exp_a[$], exp_b[$], rec_a[$], rec_b[$];
    logic [DW-1:0] src_a[$], src_b[$];
    int  n_cmp = 0, n_bad = 0;
    bit  cont_mode = 1'b1, b2b_mode = 1'b0;
    int  samples_a = 0, samples_b = 0, cyc_a = 0, rdy_cnt_a = 0, last_done_a = -1;

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name, string detail);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, detail);
    endfunction

    // Reference: enumerate the padded raster; interior positions take source pixels in order.
    task automatic add_frame(input bit which, input bit seq, input logic [DW-1:0] pad);
        int w  = which ? BW : AW;
        int h  = which ? BH : AH;
        int p  = which ? BP : AP;
        int ow = w + 2 * p;
        int oh = h + 2 * p;
        int k  = 0;
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                samp_t s;
                s.border = (r < p) || (r >= oh - p) || (c < p) || (c >= ow - p);
                s.sof    = (r == 0) && (c == 0);
                s.eol    = (c == ow - 1);
                s.done   = (r == oh - 1) && (c == ow - 1);
                if (s.border) begin
                    s.data = pad;
                end else begin
                    k++;
                    s.data = seq ? DW'(k) : ($urandom() | 32'h1);
                    if (which) src_b.push_back(s.data);
                    else       src_a.push_back(s.data);
                end
                if (which) exp_b.push_back(s);
                else       exp_a.push_back(s);
            end
        end
    endtask

    always @(negedge clk) begin
        samp_t e, got;
        if (reset) begin
            exp_a.delete();
            rdy_cnt_a = 0;
        end else begin
            cyc_a++;
            if (ifa.in_ready) rdy_cnt_a++;
            if (ifa.out_valid) begin
                samples_a++;
                got.data = ifa.out_data; got.sof = ifa.out_sof; got.eol = ifa.out_eol;
                got.done = ifa.frame_done; got.border = 1'b0;
                rec_a.push_back(got);
                $display("A sample %0d: data=%h sof=%b eol=%b done=%b", samples_a,
                         ifa.out_data, ifa.out_sof, ifa.out_eol, ifa.frame_done);
                if (exp_a.size() == 0) begin
                    fail("a_extra_sample", "out_valid=1, required no sample");
                end else begin
                    e = exp_a.pop_front();
                    chk("a_data", ifa.out_data, e.data);
                    chk("a_sof", ifa.out_sof, e.sof);
                    chk("a_eol", ifa.out_eol, e.eol);
                    chk("a_frame_done", ifa.frame_done, e.done);
                end
                if (ifa.out_sof && b2b_mode && last_done_a >= 0)
                    chk("a_sof_after_done", cyc_a - last_done_a, 2);
                if (ifa.frame_done) begin
                    if (cont_mode) chk("a_ready_cycles", rdy_cnt_a, AW * AH);
                    rdy_cnt_a   = 0;
                    last_done_a = cyc_a;
                end
            end else begin
                chk("a_idle_flags", {ifa.out_sof, ifa.out_eol, ifa.frame_done}, 0);
                if (exp_a.size() > 0 && !exp_a[0].sof && (cont_mode || exp_a[0].border))
                    fail("a_gap", $sformatf("out_valid=0, required 1 (border=%0b)", exp_a[0].border));
            end
        end
    end

    always @(negedge clk) begin
        samp_t e, got;
        if (reset) begin
            exp_b.delete();
        end else if (ifb.out_valid) begin
            samples_b++;
            got.data = ifb.out_data; got.sof = ifb.out_sof; got.eol = ifb.out_eol;
            got.done = ifb.frame_done; got.border = 1'b0;
            rec_b.push_back(got);
            $display("B sample %0d: data=%h sof=%b eol=%b done=%b", samples_b,
                     ifb.out_data, ifb.out_sof, ifb.out_eol, ifb.frame_done);
            if (exp_b.size() == 0) begin
                fail("b_extra_sample", "out_valid=1, required no sample");
            end else begin
                e = exp_b.pop_front();
                chk("b_data", ifb.out_data, e.data);
                chk("b_sof", ifb.out_sof, e.sof);
                chk("b_eol", ifb.out_eol, e.eol);
                chk("b_frame_done", ifb.frame_done, e.done);
            end
        end else begin
            chk("b_idle_flags", {ifb.out_sof, ifb.out_eol, ifb.frame_done}, 0);
            if (exp_b.size() > 0 && !exp_b[0].sof && (cont_mode || exp_b[0].border))
                fail("b_gap", $sformatf("out_valid=0, required 1 (border=%0b)", exp_b[0].border));
        end
    end

    // Source driver: presents queued pixels, pops on each accepted transfer.
    task automatic run(input bit which, input bit gaps, input int abort_at);
        int base = samples_a;
        bit take;
        for (int n = 0; n < 3000; n++) begin
            if (which) begin
                ifb.in_valid = (src_b.size() > 0) && (!gaps || $urandom_range(0, 1) == 1);
                ifb.in_data  = (src_b.size() > 0) ? src_b[0] : '0;
            end else begin
                ifa.in_valid = (src_a.size() > 0) && (!gaps || $urandom_range(0, 1) == 1);
                ifa.in_data  = (src_a.size() > 0) ? src_a[0] : '0;
            end
`ifdef ZERO_PAD_VALUE_EN
            if (pad_chg_mode && (samples_a - base >= 10)) pad_value_a = '0;
`endif
            @(negedge clk);
            take = which ? (ifb.in_valid && ifb.in_ready) : (ifa.in_valid && ifa.in_ready);
            @(posedge clk);
            if (take) begin
                if (which) void'(src_b.pop_front());
                else       void'(src_a.pop_front());
            end
            if (!which && abort_at > 0 && (samples_a - base >= abort_at)) begin
                ifa.in_valid = 1'b0;
                return;
            end
            if (which ? (exp_b.size() == 0 && src_b.size() == 0)
                      : (exp_a.size() == 0 && src_a.size() == 0)) begin
                ifa.in_valid = 1'b0;
                ifb.in_valid = 1'b0;
                return;
            end
            #1;
        end
        fail("run_timeout", $sformatf("frame unfinished after 3000 cycles, %0d samples outstanding",
                                      which ? exp_b.size() : exp_a.size()));
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
    endtask

    initial begin
        int nz;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a_ctrl", {ifa.out_valid, ifa.out_sof, ifa.out_eol, ifa.frame_done, ifa.in_ready}, 0);
        chk("reset_a_data", ifa.out_data, 0);
        chk("reset_b_ctrl", {ifb.out_valid, ifb.out_sof, ifb.out_eol, ifb.frame_done, ifb.in_ready}, 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Basic frame, in_valid held high, pixels 1..12.
        cont_mode = 1'b1;
        rec_a.delete();
        add_frame(0, 1'b1, '0);
        run(0, 1'b0, 0);
        chk("basic_count", rec_a.size(), 30);
        if (rec_a.size() >= 30) begin
            chk("basic_r0c3_zero", rec_a[3].data, 0);
            chk("basic_r1c1", rec_a[7].data, 1);
            chk("basic_r1c5_zero", rec_a[11].data, 0);
            chk("basic_r3c4", rec_a[22].data, 12);
            chk("basic_r4c2_zero", rec_a[26].data, 0);
            chk("basic_eol_s6", rec_a[5].eol, 1);
            chk("basic_eol_s7", rec_a[6].eol, 0);
            chk("basic_done_s29", rec_a[28].done, 0);
            chk("basic_done_s30", rec_a[29].done, 1);
        end

        // Same frame with a toggling source, then random data frames.
        cont_mode = 1'b0;
        rec_a.delete();
        add_frame(0, 1'b1, '0);
        run(0, 1'b1, 0);
        chk("gaps_count", rec_a.size(), 30);
        if (rec_a.size() >= 30) chk("gaps_r3c4", rec_a[22].data, 12);
        for (int f = 0; f < 3; f++) begin
            add_frame(0, 1'b0, '0);
            run(0, 1'b1, 0);
        end

        // Back-to-back frames with continuous source.
        cont_mode   = 1'b1;
        b2b_mode    = 1'b1;
        last_done_a = -1;
        rec_a.delete();
        add_frame(0, 1'b0, '0);
        add_frame(0, 1'b0, '0);
        run(0, 1'b0, 0);
        chk("b2b_count", rec_a.size(), 60);
        b2b_mode = 1'b0;

        // Reset asserted after sample 17.
        rec_a.delete();
        add_frame(0, 1'b0, '0);
        run(0, 1'b0, 17);
        #3 reset = 1'b1;
        #1;
        chk("midreset_ctrl", {ifa.out_valid, ifa.out_sof, ifa.out_eol, ifa.frame_done, ifa.in_ready}, 0);
        chk("midreset_data", ifa.out_data, 0);
        src_a.delete();
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        rec_a.delete();
        add_frame(0, 1'b0, '0);
        run(0, 1'b0, 0);
        chk("postreset_count", rec_a.size(), 30);
        if (rec_a.size() > 0) chk("postreset_sof", rec_a[0].sof, 1);

        // PAD=2 on a 2x2 source: only the centre 2x2 of the 6x6 frame is non-zero.
        rec_b.delete();
        add_frame(1, 1'b1, '0);
        run(1, 1'b0, 0);
        chk("pad2_count", rec_b.size(), 36);
        if (rec_b.size() >= 36) begin
            chk("pad2_r2c2", rec_b[14].data, 1);
            chk("pad2_r2c3", rec_b[15].data, 2);
            chk("pad2_r3c2", rec_b[20].data, 3);
            chk("pad2_r3c3", rec_b[21].data, 4);
            nz = 0;
            foreach (rec_b[i]) if (rec_b[i].data != '0) nz++;
            chk("pad2_nonzero", nz, 4);
        end

`ifdef ZERO_PAD_VALUE_EN
        // Border word latched at frame start; the mid-frame change must not show.
        pad_value_a  = 32'hDEAD_BEEF;
        pad_chg_mode = 1'b1;
        rec_a.delete();
        add_frame(0, 1'b0, 32'hDEAD_BEEF);
        run(0, 1'b0, 0);
        pad_chg_mode = 1'b0;
        chk("padval_count", rec_a.size(), 30);
        if (rec_a.size() >= 30) begin
            chk("padval_first", rec_a[0].data, 32'hDEAD_BEEF);
            chk("padval_r2c5", rec_a[17].data, 32'hDEAD_BEEF);
            chk("padval_last", rec_a[29].data, 32'hDEAD_BEEF);
        end
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
